ahb_slave_mem: RTL and testbench

AHB-Lite memory-mapped responder that sits on one slave port of the generated AHB bus interconnect (the `slv_in`/`slv_out`/`hsel` side). It accepts pipelined address/data-phase transfers, backs them with a word-organised register array, inserts a configurable number of wait states, and returns two-cycle ERROR responses for illegal accesses. It is the reusable slave model for the CRV bench and for simple on-chip RAM/register regions.

---
 rtl/ahb_slv_pkg.sv | 43 ++++
 rtl/ahb_slave_mem_if.sv | 24 ++
 rtl/ahb_slv_mem_array.sv | 28 ++
 rtl/ahb_slave_mem.sv | 144 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ahb_slv_pkg.sv
// Shared AHB-Lite encodings, FSM state codes and decode helpers for ahb_slave_mem.
package ahb_slv_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WAIT = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_ERR1 = 3'd3;
    localparam state_t ST_ERR2 = 3'd4;

    // Sizes above word fall into the default and drive all four lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic access_legal(input logic [31:0] offset, input logic [31:0] limit,
                                          input logic [2:0] size, input logic [1:0] lo);
        return (offset < limit) && (size <= HSIZE_WORD) &&
               !((size == HSIZE_HALF) && lo[0]) &&
               !((size == HSIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-port bundle between a master/interconnect and ahb_slave_mem.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slv_mem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module ahb_slv_mem_array #(
    parameter int MEM_DEPTH = 256,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rdata
);
    logic [31:0] mem_r [MEM_DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[rd_idx];
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: pipelined address/data phases with WAIT_CYCLES wait states per OKAY beat.
// Define AHB_SLV_ERR_EN to add legality checks and the two-cycle ERROR response.
module ahb_slave_mem
    import ahb_slv_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int REGION_W    = 16
) (
    input logic            hclk,
    input logic            hreset_n,
    ahb_slave_mem_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    state_t        state_r, state_nxt_s;
    logic [3:0]    cnt_r, cnt_nxt_s;
    logic          accept_s, take_s, legal_s, wr_commit_s;
    logic [AW-1:0] in_idx_s, idx_r;
    logic [1:0]    lo_r;
    logic [2:0]    size_r;
    logic          write_r;
    logic [3:0]    wr_be_s;
    logic [31:0]   rd_word_s, fwd_word_s;
    logic [31:0]   hrdata_r;
    logic          hreadyout_r;
    logic          unused_s;

    assign accept_s    = bus.hsel & bus.hready & bus.htrans[1];
    assign take_s      = accept_s & ((state_r == ST_IDLE) | (state_r == ST_DATA) | (state_r == ST_ERR2));
    assign in_idx_s    = bus.haddr[AW+1:2];
    assign wr_commit_s = (state_r == ST_DATA) & write_r;
    assign wr_be_s     = byte_en(size_r, lo_r);
    assign unused_s    = ^{bus.hburst, bus.htrans[0], bus.haddr[REGION_W-1:0], bus.haddr};

`ifdef AHB_SLV_ERR_EN
    assign legal_s = access_legal(32'(bus.haddr[REGION_W-1:0]), 32'(MEM_DEPTH * 4),
                                  bus.hsize, bus.haddr[1:0]);
`else
    assign legal_s = 1'b1;
`endif

    ahb_slv_mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_array (
        .clk    (hclk),
        .we     (wr_commit_s),
        .be     (wr_be_s),
        .wr_idx (idx_r),
        .wdata  (bus.hwdata),
        .rd_idx (in_idx_s),
        .rdata  (rd_word_s)
    );

    // A read accepted on the same edge that commits a write to the same word sees the new lanes.
    always_comb begin
        fwd_word_s = rd_word_s;
        for (int i = 0; i < 4; i++) begin
            if (wr_commit_s && wr_be_s[i] && (idx_r == in_idx_s)) begin
                fwd_word_s[8*i +: 8] = bus.hwdata[8*i +: 8];
            end else begin
                fwd_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (take_s && !legal_s) begin
                    state_nxt_s = ST_ERR1;
                end else if (take_s && (WAIT_CYCLES > 0)) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = 4'(WAIT_CYCLES);
                end else if (take_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_DATA;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // FSM, captured address phase and registered outputs; reset drops any pending write.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            idx_r       <= '0;
            lo_r        <= 2'b00;
            size_r      <= 3'd0;
            write_r     <= 1'b0;
            hrdata_r    <= 32'd0;
            hreadyout_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hreadyout_r <= (state_nxt_s != ST_WAIT) && (state_nxt_s != ST_ERR1);
            if (take_s) begin
                idx_r   <= in_idx_s;
                lo_r    <= bus.haddr[1:0];
                size_r  <= bus.hsize;
                write_r <= bus.hwrite & legal_s;
            end
            if (take_s && legal_s && !bus.hwrite) begin
                hrdata_r <= fwd_word_s;
            end
        end
    end

`ifdef AHB_SLV_ERR_EN
    logic hresp_r;

    // ERROR is flagged for both error data-phase cycles.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            hresp_r <= HRESP_OKAY;
        end else begin
            hresp_r <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    assign bus.hresp = hresp_r;
`else
    assign bus.hresp = HRESP_OKAY;
`endif

    assign bus.hrdata    = hrdata_r;
    assign bus.hreadyout = hreadyout_r;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait instance and one three-wait-state instance.
module tb_ahb_slave_mem;
    import ahb_slv_pkg::*;

    logic hclk = 1'b0;
    logic rst0_n;
    logic rst3_n;
    logic hready_ovr0;
    int   n_assert = 0;
    int   n_fail   = 0;

    ahb_slave_mem_if b0 ();
    ahb_slave_mem_if b3 ();

    assign b0.hready = b0.hreadyout & hready_ovr0;
    assign b3.hready = b3.hreadyout;

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(0), .REGION_W(16)) u0 (
        .hclk(hclk), .hreset_n(rst0_n), .bus(b0)
    );

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(3), .REGION_W(16)) u3 (
        .hclk(hclk), .hreset_n(rst3_n), .bus(b3)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic ap0(input logic [31:0] a, input logic w, input logic [2:0] s, input htrans_t tr);
        b0.hsel = 1'b1; b0.haddr = a; b0.hwrite = w; b0.hsize = s; b0.htrans = tr; b0.hburst = 3'd0;
    endtask

    task automatic idle0();
        b0.hsel = 1'b0; b0.haddr = 32'd0; b0.hwrite = 1'b0; b0.hsize = 3'd0;
        b0.htrans = HTRANS_IDLE; b0.hburst = 3'd0;
    endtask

    task automatic ap3(input logic [31:0] a, input logic w, input logic [2:0] s, input htrans_t tr);
        b3.hsel = 1'b1; b3.haddr = a; b3.hwrite = w; b3.hsize = s; b3.htrans = tr; b3.hburst = 3'd0;
    endtask

    task automatic idle3();
        b3.hsel = 1'b0; b3.haddr = 32'd0; b3.hwrite = 1'b0; b3.hsize = 3'd0;
        b3.htrans = HTRANS_IDLE; b3.hburst = 3'd0;
    endtask

    initial begin
        rst0_n = 1'b1; rst3_n = 1'b1; hready_ovr0 = 1'b1;
        idle0(); idle3();
        b0.hwdata = 32'd0; b3.hwdata = 32'd0;
        #1;
        rst0_n = 1'b0; rst3_n = 1'b0;
        #1;
        chk("rst_hreadyout", b0.hreadyout, 32'd1);
        chk("rst_hresp", b0.hresp, 32'd0);
        chk("rst_hrdata", b0.hrdata, 32'd0);
        chk("rst3_hreadyout", b3.hreadyout, 32'd1);
        step(); step();
        rst0_n = 1'b1; rst3_n = 1'b1;

        // Word write then read of 0x10, idle gap between.
        ap0(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b0.hwdata = 32'hDEADBEEF; idle0();
        chk("wr10_hreadyout", b0.hreadyout, 32'd1);
        chk("wr10_hresp", b0.hresp, 32'd0);
        step();
        ap0(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("rd10_hreadyout", b0.hreadyout, 32'd1);
        chk("rd10_hrdata", b0.hrdata, 32'hDEADBEEF);
        step();

        // Lane writes: word 0x30, byte 0x31, halfword 0x32, then pipelined word read.
        ap0(32'h30, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b0.hwdata = 32'h55667788; ap0(32'h31, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ); step();
        b0.hwdata = 32'h0000AA00; ap0(32'h32, 1'b1, HSIZE_HALF, HTRANS_NONSEQ); step();
        b0.hwdata = 32'h12340000; ap0(32'h30, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("lanes_fwd_hrdata", b0.hrdata, 32'h1234AA88);
        step();
        ap0(32'h30, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("lanes_mem_hrdata", b0.hrdata, 32'h1234AA88);
        step();

        // Back-to-back write/read of 0x40 at one transfer per cycle.
        ap0(32'h40, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b0.hwdata = 32'hCAFEF00D; ap0(32'h40, 1'b0, HSIZE_WORD, HTRANS_SEQ);
        chk("b2b_wr_hreadyout", b0.hreadyout, 32'd1);
        step();
        idle0();
        chk("b2b_rd_hreadyout", b0.hreadyout, 32'd1);
        chk("b2b_rd_hrdata", b0.hrdata, 32'hCAFEF00D);
        step();

        // hready low and BUSY are not transfers: 0x10 must keep its data.
        hready_ovr0 = 1'b0; ap0(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        hready_ovr0 = 1'b1; b0.hwdata = 32'h0BADF00D;
        ap0(32'h10, 1'b1, HSIZE_WORD, HTRANS_BUSY); step();
        idle0(); step();
        ap0(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("ignored_hrdata", b0.hrdata, 32'hDEADBEEF);
        step();

`ifdef AHB_SLV_ERR_EN
        // Out-of-range and misaligned writes give a two-cycle ERROR and leave word 0 intact.
        ap0(32'h0, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b0.hwdata = 32'h01020304; ap0(32'h400, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b0.hwdata = 32'hFFFFFFFF; idle0();
        chk("oor_c1_hreadyout", b0.hreadyout, 32'd0);
        chk("oor_c1_hresp", b0.hresp, 32'd1);
        step();
        chk("oor_c2_hreadyout", b0.hreadyout, 32'd1);
        chk("oor_c2_hresp", b0.hresp, 32'd1);
        step();
        chk("oor_after_hresp", b0.hresp, 32'd0);
        ap0(32'h2, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("mis_c1_hreadyout", b0.hreadyout, 32'd0);
        chk("mis_c1_hresp", b0.hresp, 32'd1);
        step();
        chk("mis_c2_hreadyout", b0.hreadyout, 32'd1);
        chk("mis_c2_hresp", b0.hresp, 32'd1);
        step();
        ap0(32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("err_mem_hrdata", b0.hrdata, 32'h01020304);
        step();
`else
        // Without error checks, 0x450 aliases onto 0x50 and hsize 3 acts as a word.
        ap0(32'h450, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b0.hwdata = 32'h11112222; idle0(); step();
        ap0(32'h50, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("alias_hrdata", b0.hrdata, 32'h11112222);
        chk("alias_hresp", b0.hresp, 32'd0);
        step();
        ap0(32'h60, 1'b1, 3'd3, HTRANS_NONSEQ); step();
        b0.hwdata = 32'hA5A5A5A5; idle0(); step();
        ap0(32'h60, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle0();
        chk("size3_hrdata", b0.hrdata, 32'hA5A5A5A5);
        step();
`endif

        // Three wait states: hreadyout low for three cycles, high on the fourth.
        ap3(32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b3.hwdata = 32'h87654321; idle3();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("w3_wr_rdy_c%0d", c), b3.hreadyout, (c == 4) ? 32'd1 : 32'd0);
            step();
        end
        ap3(32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle3();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("w3_rd_rdy_c%0d", c), b3.hreadyout, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("w3_rd_data_c%0d", c), b3.hrdata, 32'h87654321);
            step();
        end

        // Reset during a wait-state write: outputs clear at once and the write is lost.
        ap3(32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ); step();
        b3.hwdata = 32'hFFFF0000; idle3();
        chk("rstmid_pre_rdy", b3.hreadyout, 32'd0);
        step();
        #2;
        rst3_n = 1'b0;
        #1;
        chk("rstmid_hreadyout", b3.hreadyout, 32'd1);
        chk("rstmid_hresp", b3.hresp, 32'd0);
        chk("rstmid_hrdata", b3.hrdata, 32'd0);
        step(); step();
        rst3_n = 1'b1;
        ap3(32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); step();
        idle3();
        step(); step(); step();
        chk("rstmid_rd_rdy", b3.hreadyout, 32'd1);
        chk("rstmid_rd_hrdata", b3.hrdata, 32'h87654321);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
